// File: rtl/div_arbiter_if.sv
// Bundle of request, response and divider signals for the shared-divider
// arbiter. The arbiter connects through the slave modport; the surrounding
// requesters, consumer and divider connect through the master modport.
interface div_arbiter_if #(
  parameter int D_W   = 16,
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
);
  logic [N_REQ-1:0]     I_REQ_VLD;
  logic [N_REQ*D_W-1:0] I_REQ_DIVIDEND;
  logic [N_REQ*D_W-1:0] I_REQ_DIVISOR;
  logic [N_REQ-1:0]     O_REQ_RDY;
  logic                 O_RSP_VLD;
  logic [ID_W-1:0]      O_RSP_ID;
  logic [D_W-1:0]       O_RSP_QUOTIENT;
  logic                 O_RSP_DIVZERO;
  logic                 I_RSP_RDY;
  logic                 O_DIV_START;
  logic [D_W-1:0]       O_DIV_DIVIDEND;
  logic [D_W-1:0]       O_DIV_DIVISOR;
  logic [D_W-1:0]       I_DIV_QUOTIENT;
  logic                 I_DIV_OUT_VLD;

  modport slave (
    input  I_REQ_VLD, I_REQ_DIVIDEND, I_REQ_DIVISOR, I_RSP_RDY,
           I_DIV_QUOTIENT, I_DIV_OUT_VLD,
    output O_REQ_RDY, O_RSP_VLD, O_RSP_ID, O_RSP_QUOTIENT, O_RSP_DIVZERO,
           O_DIV_START, O_DIV_DIVIDEND, O_DIV_DIVISOR
  );

  modport master (
    output I_REQ_VLD, I_REQ_DIVIDEND, I_REQ_DIVISOR, I_RSP_RDY,
           I_DIV_QUOTIENT, I_DIV_OUT_VLD,
    input  O_REQ_RDY, O_RSP_VLD, O_RSP_ID, O_RSP_QUOTIENT, O_RSP_DIVZERO,
           O_DIV_START, O_DIV_DIVIDEND, O_DIV_DIVISOR
  );
endinterface

// File: rtl/div_arbiter.sv
// Round-robin scheduler sharing one signed divider among N_REQ requesters.
// One job in flight: accept a request, hold operands and start for the whole
// divide (or bypass on a zero divisor), then present the quotient with the
// requester ID until the consumer takes it.
module div_arbiter #(
  parameter int D_W   = 16,
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic          I_CLK,
  input  logic          I_RST,
  div_arbiter_if.slave  bus
);

  localparam int PW = ID_W + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                 state_q;
  state_t                 state_d;
  logic [ID_W-1:0]        rr_ptr_q;
  logic [ID_W-1:0]        grant_id;
  logic [ID_W-1:0]        ptr_next;
  logic                   grant_any;
  logic                   accept;
  logic [PW-1:0]          cand;
  logic [PW-1:0]          nxt;
  logic signed [D_W-1:0]  sel_dividend;
  logic signed [D_W-1:0]  sel_divisor;
  logic signed [D_W-1:0]  dividend_q;
  logic signed [D_W-1:0]  divisor_q;
  logic signed [D_W-1:0]  quot_q;
  logic [ID_W-1:0]        id_q;
  logic                   divzero_q;

  // First valid requester at or above the rr pointer, wrapping at N_REQ-1.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = rr_ptr_q;
    cand      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = {1'b0, rr_ptr_q} + PW'(k);
      if (cand >= PW'(N_REQ)) cand = cand - PW'(N_REQ);
      if (!grant_any && bus.I_REQ_VLD[cand[ID_W-1:0]]) begin
        grant_any = 1'b1;
        grant_id  = cand[ID_W-1:0];
      end
    end
  end

  assign nxt          = {1'b0, grant_id} + PW'(1);
  assign ptr_next     = (nxt >= PW'(N_REQ)) ? '0 : nxt[ID_W-1:0];
  assign sel_dividend = bus.I_REQ_DIVIDEND[grant_id*D_W +: D_W];
  assign sel_divisor  = bus.I_REQ_DIVISOR[grant_id*D_W +: D_W];

  // Next-state and accept decode; ready is withheld while reset is asserted
  // so no requester believes it was accepted by a register held in reset.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (grant_any && !I_RST) begin
          accept  = 1'b1;
          state_d = (sel_divisor == '0) ? S_RESP : S_RUN;
        end
      end
      S_RUN: begin
        if (bus.I_DIV_OUT_VLD) state_d = S_RESP;
      end
      S_RESP: begin
        if (bus.I_RSP_RDY) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge I_CLK or posedge I_RST) begin
    if (I_RST) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Job registers: operands and ID captured at accept, result captured at
  // accept (zero-divisor bypass) or on the divider done pulse while running.
  always_ff @(posedge I_CLK or posedge I_RST) begin
    if (I_RST) begin
      rr_ptr_q   <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      id_q       <= '0;
      quot_q     <= '0;
      divzero_q  <= 1'b0;
    end else begin
      if (accept) begin
        rr_ptr_q   <= ptr_next;
        dividend_q <= sel_dividend;
        divisor_q  <= sel_divisor;
        id_q       <= grant_id;
        if (sel_divisor == '0) begin
          quot_q    <= '0;
          divzero_q <= 1'b1;
        end
      end
      if (state_q == S_RUN && bus.I_DIV_OUT_VLD) begin
        quot_q    <= bus.I_DIV_QUOTIENT;
        divzero_q <= 1'b0;
      end
    end
  end

  // Start is a state decode so it drops on the done edge and on async reset,
  // before the divider can return to idle and relaunch.
  assign bus.O_REQ_RDY      = accept ? (N_REQ'(1) << grant_id) : '0;
  assign bus.O_DIV_START    = (state_q == S_RUN);
  assign bus.O_DIV_DIVIDEND = dividend_q;
  assign bus.O_DIV_DIVISOR  = divisor_q;
  assign bus.O_RSP_VLD      = (state_q == S_RESP);
  assign bus.O_RSP_ID       = id_q;
  assign bus.O_RSP_QUOTIENT = quot_q;
  assign bus.O_RSP_DIVZERO  = divzero_q;

endmodule
